// File: rtl/rf_pkg.sv
// Shared widths, queue entry type and write-source encoding for the RISC-4
// register-file write/operand front end.
package rf_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned ADDR_W = 4;
   localparam logic [ADDR_W-1:0] R0_ADDR = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              kill;
   } lq_entry_t;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_LQ
   } wb_src_e;

   function automatic logic is_r0(input logic [ADDR_W-1:0] addr);
      return addr == R0_ADDR;
   endfunction

endpackage

// File: rtl/rf_wb_lq.sv
// Load-return circular queue with kill-by-address and per-port live-match lookup.
// RF_LQ_BYPASS_EN adds youngest-match data outputs for operand forwarding.
module rf_wb_lq
   import rf_pkg::*;
#(
   parameter  int unsigned LQ_DEPTH = 2,
   localparam int unsigned CNT_W    = $clog2(LQ_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  lq_entry_t         i_push_entry,
   input  logic              i_pop,
   input  logic              i_kill_valid,
   input  logic [ADDR_W-1:0] i_kill_addr,
   input  logic [ADDR_W-1:0] i_match_addr_a,
   input  logic [ADDR_W-1:0] i_match_addr_b,
   output lq_entry_t         o_head,
   output logic              o_empty,
   output logic              o_full,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_hit_a,
   output logic              o_hit_b
`ifdef RF_LQ_BYPASS_EN
   ,
   output logic [DATA_W-1:0] o_fwd_data_a,
   output logic [DATA_W-1:0] o_fwd_data_b
`endif
);

   localparam int unsigned PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

   lq_entry_t        r_mem [LQ_DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(LQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            r_mem[PTR_W'(i)] <= '0;
         end
      end else begin
         if (i_kill_valid) begin
            for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
               if (r_mem[PTR_W'(i)].addr == i_kill_addr) begin
                  r_mem[PTR_W'(i)].kill <= 1'b1;
               end
            end
         end
         if (i_push) begin
            r_mem[r_tail] <= i_push_entry;
            r_tail        <= ptr_inc(r_tail);
         end
         if (i_pop) begin
            r_head <= ptr_inc(r_head);
         end
         if (i_push && !i_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!i_push && i_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Walk oldest to youngest so the last live match seen is the youngest one.
   always_comb begin
      int unsigned v_slot;
      lq_entry_t   v_ent;
      v_slot  = 0;
      v_ent   = '0;
      o_hit_a = 1'b0;
      o_hit_b = 1'b0;
`ifdef RF_LQ_BYPASS_EN
      o_fwd_data_a = '0;
      o_fwd_data_b = '0;
`endif
      for (int unsigned k = 0; k < LQ_DEPTH; k++) begin
         v_slot = 32'(r_head) + k;
         if (v_slot >= LQ_DEPTH) begin
            v_slot = v_slot - LQ_DEPTH;
         end
         v_ent = r_mem[PTR_W'(v_slot)];
         if ((k < 32'(r_count)) && !v_ent.kill) begin
            if (v_ent.addr == i_match_addr_a) begin
               o_hit_a = 1'b1;
`ifdef RF_LQ_BYPASS_EN
               o_fwd_data_a = v_ent.data;
`endif
            end
            if (v_ent.addr == i_match_addr_b) begin
               o_hit_b = 1'b1;
`ifdef RF_LQ_BYPASS_EN
               o_fwd_data_b = v_ent.data;
`endif
            end
         end
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_W'(LQ_DEPTH));
   assign o_count = r_count;

endmodule

// File: rtl/rf_wb_ctrl.sv
// RF write-port arbiter (ALU writeback over queued load returns) and operand forwarding.
// RF_LQ_BYPASS_EN: forward from live queue entries; otherwise stall on a live match.
module rf_wb_ctrl
   import rf_pkg::*;
#(
   parameter  int unsigned LQ_DEPTH = 2,
   localparam int unsigned CNT_W    = $clog2(LQ_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_wb_valid,
   input  logic [ADDR_W-1:0] alu_wb_addr,
   input  logic [DATA_W-1:0] alu_wb_data,
   input  logic              ld_wb_valid,
   output logic              ld_wb_ready,
   input  logic [ADDR_W-1:0] ld_wb_addr,
   input  logic [DATA_W-1:0] ld_wb_data,
   output logic              rf_write_enable,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   input  logic [ADDR_W-1:0] op_addr_a,
   input  logic [ADDR_W-1:0] op_addr_b,
   output logic [ADDR_W-1:0] rf_read_addr_a,
   output logic [ADDR_W-1:0] rf_read_addr_b,
   input  logic [DATA_W-1:0] rf_read_data_a,
   input  logic [DATA_W-1:0] rf_read_data_b,
   output logic [DATA_W-1:0] op_data_a,
   output logic [DATA_W-1:0] op_data_b,
   output logic              op_stall,
   output logic [CNT_W-1:0]  lq_count
);

   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;

   wb_src_e           w_src;
   logic              w_push;
   logic              w_pop;
   logic              w_lq_empty;
   logic              w_lq_full;
   logic              w_hit_a;
   logic              w_hit_b;
   lq_entry_t         w_push_entry;
   lq_entry_t         w_head;
`ifdef RF_LQ_BYPASS_EN
   logic [DATA_W-1:0] w_fwd_a;
   logic [DATA_W-1:0] w_fwd_b;
`endif

   assign ld_wb_ready = !w_lq_full;
   assign w_push      = ld_wb_valid && !w_lq_full;
   assign w_pop       = (w_src == WB_LQ);

   // A load entering alongside an ALU write to the same register is older, so it enters dead.
   assign w_push_entry = '{
      addr: ld_wb_addr,
      data: ld_wb_data,
      kill: is_r0(ld_wb_addr) || (alu_wb_valid && (alu_wb_addr == ld_wb_addr))
   };

   rf_wb_lq #(
      .LQ_DEPTH(LQ_DEPTH)
   ) u_lq (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_push        (w_push),
      .i_push_entry  (w_push_entry),
      .i_pop         (w_pop),
      .i_kill_valid  (alu_wb_valid),
      .i_kill_addr   (alu_wb_addr),
      .i_match_addr_a(op_addr_a),
      .i_match_addr_b(op_addr_b),
      .o_head        (w_head),
      .o_empty       (w_lq_empty),
      .o_full        (w_lq_full),
      .o_count       (lq_count),
      .o_hit_a       (w_hit_a),
      .o_hit_b       (w_hit_b)
`ifdef RF_LQ_BYPASS_EN
      ,
      .o_fwd_data_a  (w_fwd_a),
      .o_fwd_data_b  (w_fwd_b)
`endif
   );

   always_comb begin
      w_src = WB_NONE;
      if (alu_wb_valid) begin
         w_src = WB_ALU;
      end else if (!w_lq_empty) begin
         w_src = WB_LQ;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         case (w_src)
            WB_ALU: begin
               r_we    <= !is_r0(alu_wb_addr);
               r_waddr <= alu_wb_addr;
               r_wdata <= alu_wb_data;
            end
            WB_LQ: begin
               r_we    <= !w_head.kill;
               r_waddr <= w_head.addr;
               r_wdata <= w_head.data;
            end
            default: r_we <= 1'b0;
         endcase
      end
   end

   assign rf_write_enable = r_we;
   assign rf_write_addr   = r_waddr;
   assign rf_write_data   = r_wdata;
   assign rf_read_addr_a  = op_addr_a;
   assign rf_read_addr_b  = op_addr_b;

   // Later assignments win: RF < write stage < queue < r0.
   always_comb begin
      op_data_a = rf_read_data_a;
      op_data_b = rf_read_data_b;
      op_stall  = 1'b0;
      if (r_we && (r_waddr == op_addr_a)) begin
         op_data_a = r_wdata;
      end
      if (r_we && (r_waddr == op_addr_b)) begin
         op_data_b = r_wdata;
      end
`ifdef RF_LQ_BYPASS_EN
      if (w_hit_a) begin
         op_data_a = w_fwd_a;
      end
      if (w_hit_b) begin
         op_data_b = w_fwd_b;
      end
`else
      op_stall = (!is_r0(op_addr_a) && w_hit_a) || (!is_r0(op_addr_b) && w_hit_b);
`endif
      if (is_r0(op_addr_a)) begin
         op_data_a = '0;
      end
      if (is_r0(op_addr_b)) begin
         op_data_b = '0;
      end
   end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl with a register file behind it: directed vector table,
// reset-with-queued-loads sequence, then random traffic against a queue-based model.
module tb_rf_wb_ctrl;

   localparam int LQ_DEPTH = 2;
   localparam int CNT_W    = $clog2(LQ_DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             alu_wb_valid;
   logic [3:0]       alu_wb_addr;
   logic [3:0]       alu_wb_data;
   logic             ld_wb_valid;
   logic             ld_wb_ready;
   logic [3:0]       ld_wb_addr;
   logic [3:0]       ld_wb_data;
   logic             rf_write_enable;
   logic [3:0]       rf_write_addr;
   logic [3:0]       rf_write_data;
   logic [3:0]       op_addr_a;
   logic [3:0]       op_addr_b;
   logic [3:0]       rf_read_addr_a;
   logic [3:0]       rf_read_addr_b;
   logic [3:0]       rf_read_data_a;
   logic [3:0]       rf_read_data_b;
   logic [3:0]       op_data_a;
   logic [3:0]       op_data_b;
   logic             op_stall;
   logic [CNT_W-1:0] lq_count;

   int n_checks = 0;
   int n_errors = 0;

   rf_wb_ctrl #(
      .LQ_DEPTH(LQ_DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .alu_wb_valid   (alu_wb_valid),
      .alu_wb_addr    (alu_wb_addr),
      .alu_wb_data    (alu_wb_data),
      .ld_wb_valid    (ld_wb_valid),
      .ld_wb_ready    (ld_wb_ready),
      .ld_wb_addr     (ld_wb_addr),
      .ld_wb_data     (ld_wb_data),
      .rf_write_enable(rf_write_enable),
      .rf_write_addr  (rf_write_addr),
      .rf_write_data  (rf_write_data),
      .op_addr_a      (op_addr_a),
      .op_addr_b      (op_addr_b),
      .rf_read_addr_a (rf_read_addr_a),
      .rf_read_addr_b (rf_read_addr_b),
      .rf_read_data_a (rf_read_data_a),
      .rf_read_data_b (rf_read_data_b),
      .op_data_a      (op_data_a),
      .op_data_b      (op_data_b),
      .op_stall       (op_stall),
      .lq_count       (lq_count)
   );

   always #5 clk = ~clk;

   // Register file behind the block: r0 never written, async read.
   logic [3:0] env_rf [16] = '{default: '0};
   always @(posedge clk) begin
      if (rf_write_enable && (rf_write_addr != 4'd0)) env_rf[rf_write_addr] <= rf_write_data;
   end
   assign rf_read_data_a = env_rf[rf_read_addr_a];
   assign rf_read_data_b = env_rf[rf_read_addr_b];

   // Reference model: program-order list of returned loads plus the pending RF write.
   typedef struct {
      logic [3:0] addr;
      logic [3:0] data;
      bit         kill;
   } ment_t;

   ment_t      mq[$];
   logic       m_we;
   logic [3:0] m_wa;
   logic [3:0] m_wd;
   logic [3:0] m_rf [16] = '{default: '0};

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_we = 1'b0;
      m_wa = '0;
      m_wd = '0;
   endfunction

   function automatic void model_op(input logic [3:0] a, output logic [3:0] d, output bit st);
      bit         hit = 1'b0;
      logic [3:0] hd  = '0;
      foreach (mq[i]) if (!mq[i].kill && mq[i].addr == a) begin hit = 1'b1; hd = mq[i].data; end
      st = 1'b0;
      if (a == 4'd0) d = '0;
      else begin
`ifdef RF_LQ_BYPASS_EN
         if (hit) d = hd;
         else if (m_we && m_wa == a) d = m_wd;
         else d = m_rf[a];
`else
         st = hit;
         d  = (m_we && m_wa == a) ? m_wd : m_rf[a];
`endif
      end
   endfunction

   function automatic void model_update();
      bit push;
      ment_t e;
      if (m_we && m_wa != 4'd0) m_rf[m_wa] = m_wd;
      push = ld_wb_valid && (mq.size() < LQ_DEPTH);
      if (alu_wb_valid) begin
         foreach (mq[i]) if (mq[i].addr == alu_wb_addr) mq[i].kill = 1'b1;
         m_we = (alu_wb_addr != 4'd0);
         m_wa = alu_wb_addr;
         m_wd = alu_wb_data;
      end else if (mq.size() != 0) begin
         e    = mq.pop_front();
         m_we = !e.kill;
         m_wa = e.addr;
         m_wd = e.data;
      end else begin
         m_we = 1'b0;
      end
      if (push) mq.push_back('{ld_wb_addr, ld_wb_data,
                               (ld_wb_addr == 4'd0) || (alu_wb_valid && alu_wb_addr == ld_wb_addr)});
   endfunction

   task automatic model_check(input string tag);
      logic [3:0] ea, eb;
      bit sa, sb;
      model_op(op_addr_a, ea, sa);
      model_op(op_addr_b, eb, sb);
      chk({tag, " ready"}, 4'(ld_wb_ready), 4'(mq.size() < LQ_DEPTH));
      chk({tag, " count"}, 4'(lq_count), 4'(mq.size()));
      chk({tag, " we"}, 4'(rf_write_enable), 4'(m_we));
      chk({tag, " waddr"}, rf_write_addr, m_wa);
      chk({tag, " wdata"}, rf_write_data, m_wd);
      chk({tag, " op_a"}, op_data_a, ea);
      chk({tag, " op_b"}, op_data_b, eb);
      chk({tag, " stall"}, 4'(op_stall), 4'(sa || sb));
   endtask

   task automatic drive(input logic av, input logic [3:0] aa, input logic [3:0] ad,
                        input logic lv, input logic [3:0] la, input logic [3:0] ld,
                        input logic [3:0] oa, input logic [3:0] ob);
      alu_wb_valid = av; alu_wb_addr = aa; alu_wb_data = ad;
      ld_wb_valid  = lv; ld_wb_addr  = la; ld_wb_data  = ld;
      op_addr_a    = oa; op_addr_b   = ob;
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk({tag, " rst count"}, 4'(lq_count), 4'd0);
      chk({tag, " rst ready"}, 4'(ld_wb_ready), 4'd1);
      chk({tag, " rst we"}, 4'(rf_write_enable), 4'd0);
      chk({tag, " rst waddr"}, rf_write_addr, 4'd0);
      chk({tag, " rst wdata"}, rf_write_data, 4'd0);
      chk({tag, " rst stall"}, 4'(op_stall), 4'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic av; logic [3:0] aa, ad;
      logic lv; logic [3:0] la, ld;
      logic [3:0] oa, ob;
      logic rdy; logic [3:0] cnt; logic we; logic [3:0] wa, wd;
      logic [3:0] a_byp, b_byp, a_nb, b_nb; logic st_nb;
   } vec_t;

   function automatic vec_t mk(input int av, aa, ad, lv, la, ld, oa, ob,
                               rdy, cnt, we, wa, wd, ab, bb, an, bn, sn);
      vec_t v;
      v.av = av[0]; v.aa = aa[3:0]; v.ad = ad[3:0];
      v.lv = lv[0]; v.la = la[3:0]; v.ld = ld[3:0];
      v.oa = oa[3:0]; v.ob = ob[3:0];
      v.rdy = rdy[0]; v.cnt = cnt[3:0]; v.we = we[0]; v.wa = wa[3:0]; v.wd = wd[3:0];
      v.a_byp = ab[3:0]; v.b_byp = bb[3:0]; v.a_nb = an[3:0]; v.b_nb = bn[3:0]; v.st_nb = sn[0];
      return v;
   endfunction

   vec_t vecs [18];

   initial begin
      //            av aa ad   lv la ld   oa ob | rdy cnt we wa wd | a_byp b_byp a_nb b_nb st_nb
      vecs[0]  = mk(0, 0, 0,   0, 0, 0,   0, 0,   1, 0, 0, 0, 0,    0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 3, 5,   0, 0, 0,   3, 0,   1, 0, 0, 0, 0,    0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 0, 0,   0, 0, 0,   3, 0,   1, 0, 1, 3, 5,    5, 0, 5, 0, 0);
      vecs[3]  = mk(0, 0, 0,   0, 0, 0,   3, 0,   1, 0, 0, 3, 5,    5, 0, 5, 0, 0);
      vecs[4]  = mk(0, 0, 0,   1, 4, 1,   4, 0,   1, 0, 0, 3, 5,    0, 0, 0, 0, 0);
      vecs[5]  = mk(1, 7, 3,   1, 5, 2,   4, 5,   1, 1, 0, 3, 5,    1, 0, 0, 0, 1);
      vecs[6]  = mk(0, 0, 0,   1, 6, 9,   7, 5,   0, 2, 1, 7, 3,    3, 2, 3, 0, 1);
      vecs[7]  = mk(0, 0, 0,   0, 0, 0,   4, 6,   1, 1, 1, 4, 1,    1, 0, 1, 0, 0);
      vecs[8]  = mk(0, 0, 0,   1, 6, 7,   5, 4,   1, 0, 1, 5, 2,    2, 1, 2, 1, 0);
      vecs[9]  = mk(1, 6, 9,   0, 0, 0,   6, 0,   1, 1, 0, 5, 2,    7, 0, 0, 0, 1);
      vecs[10] = mk(0, 0, 0,   0, 0, 0,   6, 0,   1, 1, 1, 6, 9,    9, 0, 9, 0, 0);
      vecs[11] = mk(0, 0, 0,   0, 0, 0,   6, 0,   1, 0, 0, 6, 7,    9, 0, 9, 0, 0);
      vecs[12] = mk(1, 0, 15,  1, 0, 14,  0, 0,   1, 0, 0, 6, 7,    0, 0, 0, 0, 0);
      vecs[13] = mk(0, 0, 0,   0, 0, 0,   0, 0,   1, 1, 0, 0, 15,   0, 0, 0, 0, 0);
      vecs[14] = mk(0, 0, 0,   0, 0, 0,   3, 7,   1, 0, 0, 0, 14,   5, 3, 5, 3, 0);
      vecs[15] = mk(1, 2, 4,   1, 2, 10,  2, 0,   1, 0, 0, 0, 14,   0, 0, 0, 0, 0);
      vecs[16] = mk(0, 0, 0,   0, 0, 0,   2, 0,   1, 1, 1, 2, 4,    4, 0, 4, 0, 0);
      vecs[17] = mk(0, 0, 0,   0, 0, 0,   2, 0,   1, 0, 0, 2, 10,   4, 0, 4, 0, 0);

      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      @(negedge clk);
      do_reset("init");

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld,
               vecs[i].oa, vecs[i].ob);
         #1;
         chk($sformatf("row%0d ready", i), 4'(ld_wb_ready), 4'(vecs[i].rdy));
         chk($sformatf("row%0d count", i), 4'(lq_count), vecs[i].cnt);
         chk($sformatf("row%0d we", i), 4'(rf_write_enable), 4'(vecs[i].we));
         chk($sformatf("row%0d waddr", i), rf_write_addr, vecs[i].wa);
         chk($sformatf("row%0d wdata", i), rf_write_data, vecs[i].wd);
`ifdef RF_LQ_BYPASS_EN
         chk($sformatf("row%0d op_a", i), op_data_a, vecs[i].a_byp);
         chk($sformatf("row%0d op_b", i), op_data_b, vecs[i].b_byp);
         chk($sformatf("row%0d stall", i), 4'(op_stall), 4'd0);
`else
         chk($sformatf("row%0d op_a", i), op_data_a, vecs[i].a_nb);
         chk($sformatf("row%0d op_b", i), op_data_b, vecs[i].b_nb);
         chk($sformatf("row%0d stall", i), 4'(op_stall), 4'(vecs[i].st_nb));
`endif
         advance();
      end

      // Fill the queue behind busy ALU cycles, then reset with both loads pending.
      drive(1, 1, 1, 1, 8, 8, 0, 0);
      #1 model_check("rq0");
      advance();
      drive(1, 1, 2, 1, 9, 9, 8, 9);
      #1 model_check("rq1");
      advance();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1 chk("rq full count", 4'(lq_count), 4'd2);
      chk("rq full ready", 4'(ld_wb_ready), 4'd0);
      do_reset("rq");
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 8, 9);
         #1 model_check($sformatf("post%0d", i));
         advance();
      end
      chk("post rf r8", env_rf[8], 4'd0);
      chk("post rf r9", env_rf[9], 4'd0);
      chk("post rf r1", env_rf[1], 4'd1);

      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(79) == 0) begin
            do_reset($sformatf("rnd%0d", c));
         end else begin
            drive($urandom_range(99) < 45, 4'($urandom_range(7)), 4'($urandom_range(15)),
                  $urandom_range(99) < 60, 4'($urandom_range(7)), 4'($urandom_range(15)),
                  4'($urandom_range(7)), 4'($urandom_range(7)));
            #1 model_check($sformatf("rnd%0d", c));
            advance();
         end
      end

      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) advance();
      for (int r = 1; r < 16; r++) begin
         chk($sformatf("final rf r%0d", r), env_rf[r], m_rf[r]);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
